// File: rtl/mem_responder.sv
// Word-organised data memory with a req/ready/rvalid handshake and WAIT_CYCLES wait states per access.
// Define MEM_RESP_BYTE_EN to add the wstrb port and per-byte store masking.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef MEM_RESP_BYTE_EN
  input  logic [3:0]  wstrb,
`endif
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [31:0]        r_mem [DEPTH];

  logic               w_accept;
  logic               w_commit;
  logic               w_we;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;
  logic [3:0]         w_strb;
  logic               w_oor;
  logic [IDX_W-1:0]   w_idx;
  logic               w_unused_addr;

  assign w_accept = (r_state == S_IDLE) && req;

  // With zero wait states the commit edge is the accept edge, so the live inputs are used there.
  assign w_we    = (r_state == S_IDLE) ? we    : r_we;
  assign w_addr  = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? wdata : r_wdata;

`ifdef MEM_RESP_BYTE_EN
  logic [3:0] r_strb;
  assign w_strb = (r_state == S_IDLE) ? wstrb : r_strb;

  always_ff @(posedge clk) begin
    if (w_accept) r_strb <= wstrb;
  end
`else
  assign w_strb = 4'hF;
`endif

  assign w_oor         = |w_addr[31:IDX_W+2];
  assign w_idx         = w_addr[IDX_W+1:2];
  assign w_commit      = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_unused_addr = |addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready  = (r_state == S_IDLE);
    rvalid = (r_state == S_RESP);
    rdata  = (r_state == S_RESP) ? r_rdata : 32'h0;
    err    = (r_state == S_RESP) && r_err;
  end

  always_ff @(posedge clk) begin
    if (rst)                     r_cnt <= 4'd0;
    else if (w_accept)           r_cnt <= 4'(WAIT_CYCLES);
    else if (r_state == S_WAIT)  r_cnt <= r_cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  // Commit edge: the load captures the pre-write word; an aborting reset suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit) begin
      r_err   <= w_oor;
      r_rdata <= (w_we || w_oor) ? 32'h0 : r_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_we && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios then random traffic, checked every cycle against a
// transaction-level model (remaining-cycles countdown plus a word array with known-value flags).
module tb_mem_responder;
  localparam int DEPTH = 256;
  localparam int WC    = 1;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        ready, rvalid, err;
  logic [31:0] rdata;

  int checks = 0, failures = 0;

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_RESP_BYTE_EN
    .wstrb(wstrb),
`endif
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] mmem   [DEPTH];
  bit          mknown [DEPTH];
  bit          known_state = 0;
  int          ctr = 0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_strb;
  logic [31:0] m_rdata;
  logic        m_err;
  bit          m_rd_known;
  int          naccept = 0, nresp = 0, nabort = 0, cyc_n = 0, acc_cyc = 0, rv_cyc = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void commit();
    int idx;
    idx = int'(p_addr[31:2]) % DEPTH;
    m_rd_known = 1;
    if (p_addr >= 32'(4 * DEPTH)) begin
      m_err = 1'b1; m_rdata = 32'h0;
    end else begin
      m_err = 1'b0; m_rdata = 32'h0;
      if (p_we) begin
        for (int b = 0; b < 4; b++)
          if (p_strb[b]) mmem[idx][8*b +: 8] = p_wdata[8*b +: 8];
        if (p_strb == 4'hF) mknown[idx] = 1;
      end else begin
        m_rdata    = mmem[idx];
        m_rd_known = mknown[idx];
      end
    end
  endfunction

  task automatic cyc(input logic r_st, input logic rq, input logic w,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    rst = r_st; req = rq; we = w; addr = a; wdata = d; wstrb = s;
    #1;
    if (known_state) begin
      chk("ready", ready, ctr == 0);
      chk("rvalid", rvalid, ctr == 1);
      chk("err", err, (ctr == 1) ? m_err : 1'b0);
      if (ctr != 1 || m_rd_known) chk("rdata", rdata, (ctr == 1) ? m_rdata : 32'h0);
    end
    if (rvalid === 1'b1) begin
      nresp++; rv_cyc = cyc_n; last_rdata = rdata; last_err = err;
    end
    @(posedge clk);
    if (r_st) begin
      if (ctr > 1) nabort++;
      ctr = 0; known_state = 1;
    end else if (known_state) begin
      if (ctr == 0) begin
        if (rq) begin
          naccept++; acc_cyc = cyc_n;
          p_we = w; p_addr = a; p_wdata = d;
`ifdef MEM_RESP_BYTE_EN
          p_strb = s;
`else
          p_strb = 4'hF;
`endif
          ctr = WC + 1;
          if (ctr == 1) commit();
        end
      end else begin
        ctr--;
        if (ctr == 1) commit();
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc(1'b0, 1'b1, w, a, d, s);
    repeat (WC + 1) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  logic [31:0] addr_tbl [9] = '{32'h0, 32'h4, 32'h10, 32'h13, 32'h20, 32'h3FC,
                                32'h400, 32'h800, 32'hFFFF_FFFC};

  initial begin
    int a0, r0;
    rst = 1; req = 0; we = 0; addr = 0; wdata = 0; wstrb = 0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'h10, 32'h5555AAAA, 4'hF);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    acc(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("t2_store_latency", rv_cyc - acc_cyc, WC + 1);
    acc(1'b0, 32'h10, 32'h0, 4'h0);
    chk("t2_load_latency", rv_cyc - acc_cyc, WC + 1);
    chk("t2_load_data", last_rdata, 32'hDEADBEEF);

    acc(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    acc(1'b1, 32'h400, 32'h12345678, 4'hF);
    chk("t3_store_err", last_err, 1'b1);
    acc(1'b0, 32'h400, 32'h0, 4'h0);
    chk("t3_load_err", last_err, 1'b1);
    chk("t3_load_rdata", last_rdata, 32'h0);
    acc(1'b0, 32'h0, 32'h0, 4'h0);
    chk("t3_noalias_err", last_err, 1'b0);
    chk("t3_noalias_data", last_rdata, 32'hCAFEF00D);

    a0 = naccept; r0 = nresp;
    for (int i = 0; i < 24; i++)
      cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), (i % 2 != 0) ? 32'h10 : 32'h14, $urandom, 4'hF);
    repeat (WC + 2) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("t4_accepts", naccept - a0, (24 + WC + 1) / (WC + 2));
    chk("t4_resp_per_accept", nresp - r0, naccept - a0);

    acc(1'b1, 32'h20, 32'h11111111, 4'hF);
    r0 = nresp;
    cyc(1'b0, 1'b1, 1'b1, 32'h20, 32'h22222222, 4'hF);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("t5_no_resp_aborted", nresp, r0);
    acc(1'b0, 32'h20, 32'h0, 4'h0);
    chk("t5_load_data", last_rdata, 32'h11111111);

`ifdef MEM_RESP_BYTE_EN
    acc(1'b1, 32'h8, 32'hAABBCCDD, 4'hF);
    acc(1'b1, 32'h8, 32'h00001100, 4'b0010);
    acc(1'b0, 32'h8, 32'h0, 4'h0);
    chk("t6_byte_merge", last_rdata, 32'hAABB11DD);
    acc(1'b1, 32'h8, 32'hFFFFFFFF, 4'h0);
    acc(1'b0, 32'h8, 32'h0, 4'h0);
    chk("t6_nostrobe_noop", last_rdata, 32'hAABB11DD);
`endif

    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
          addr_tbl[$urandom_range(0, 8)], $urandom, 4'($urandom));
    repeat (WC + 2) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("total_resp", nresp, naccept - nabort);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
